// File: rtl/edge_detector_multi.sv
// rtl/edge_detector_multi.sv - multi-channel synchronised, debounced edge detector with sticky flags and irq
//
// Ports:
//   clk       in   1            system clock, rising edge
//   rst_n     in   1            asynchronous reset, active-low
//   entrada   in   CHANNELS     raw asynchronous inputs
//   mode      in   2*CHANNELS   per channel [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
//   clear     in   CHANNELS     per-channel sticky-flag clear (level)
//   irq_en    in   CHANNELS     per-channel interrupt mask (1 = enabled)
//   detector  out  CHANNELS     one-cycle pulse per qualified edge
//   filtered  out  CHANNELS     debounced, synchronised level
//   sticky    out  CHANNELS     latched event flags
//   irq       out  1            |(sticky & irq_en)

module edge_detector_multi #(
    parameter int CHANNELS      = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CHANNELS-1:0]     entrada,
    input  logic [2*CHANNELS-1:0]   mode,
    input  logic [CHANNELS-1:0]     clear,
    input  logic [CHANNELS-1:0]     irq_en,
    output logic [CHANNELS-1:0]     detector,
    output logic [CHANNELS-1:0]     filtered,
    output logic [CHANNELS-1:0]     sticky,
    output logic                    irq
);

    // Count value at which a differing level has been held FILTER_CYCLES cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
    logic [CNT_W-1:0]       cnt_q  [CHANNELS];
    logic [CNT_W-1:0]       cnt_d  [CHANNELS];

    logic [CHANNELS-1:0]    sync_lvl;
    logic [CHANNELS-1:0]    filtered_d;
    logic [CHANNELS-1:0]    rise;
    logic [CHANNELS-1:0]    fall;
    logic [CHANNELS-1:0]    mode_rise;
    logic [CHANNELS-1:0]    mode_fall;
    logic [CHANNELS-1:0]    detector_d;
    logic [CHANNELS-1:0]    sticky_d;

    // Debounce filter: a new level is accepted only after it has differed from
    // the current filtered level on FILTER_CYCLES consecutive cycles; any
    // return to the filtered level restarts the count from zero.
    always_comb begin
        filtered_d = filtered;
        sync_lvl   = '0;
        mode_rise  = '0;
        mode_fall  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]     = '0;
            sync_lvl[i]  = sync_q[i][SYNC_STAGES-1];
            mode_rise[i] = mode[2*i];
            mode_fall[i] = mode[2*i+1];
            if (sync_lvl[i] != filtered[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filtered_d[i] = sync_lvl[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Edges are taken from the filtered level update itself, so the detector
    // pulse lands on the same edge that filtered changes and mode is sampled
    // only at that moment.
    assign rise       = filtered_d & ~filtered;
    assign fall       = ~filtered_d & filtered;
    assign detector_d = (rise & mode_rise) | (fall & mode_fall);

    // A fresh event has priority over a clear in the same cycle.
    assign sticky_d   = detector_d | (sticky & ~clear);

    assign irq        = |(sticky & irq_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            filtered <= '0;
            detector <= '0;
            sticky   <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], entrada[i]};
                cnt_q[i]  <= cnt_d[i];
            end
            filtered <= filtered_d;
            detector <= detector_d;
            sticky   <= sticky_d;
        end
    end

endmodule
